// File: rtl/h264coretransform_pkg.sv
// Shared constants for the H.264 core-transform macroblock sequencer:
// FSM state encodings, macroblock geometry and the output-row timeout default.
package h264coretransform_pkg;

    localparam int NUM_BLOCKS_DEF  = 24;
    localparam int TIMEOUT_DEF     = 15;
    localparam int CHROMA_CB_FIRST = 16;
    localparam int CHROMA_CR_FIRST = 20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_DS = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage

// File: rtl/h264coretransform_mb_sequencer.sv
// Walks one macroblock of 4x4 blocks through the core transform: waits for the
// quantiser, feeds four residual rows, then drains four transform rows per block.
module h264coretransform_mb_sequencer
    import h264coretransform_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MB_START,
    input  logic       XXIN_VALID,
    output logic       XXIN_READY,
    input  logic       QUANT_READY,
    output logic       CT_ENABLE,
    output logic       CT_ROW_LOAD,
    input  logic       YOUT_VALID,
    output logic [4:0] BLK_IDX,
    output logic       BLK_CHROMA,
    output logic       BLK_CR,
    output logic [1:0] OUT_ROW,
    output logic       MB_DONE,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [4:0] LAST_BLK = 5'(NUM_BLOCKS - 1);
    localparam logic [4:0] CB_FIRST = 5'(CHROMA_CB_FIRST);
    localparam logic [4:0] CR_FIRST = 5'(CHROMA_CR_FIRST);
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [4:0] r_blk_idx;
    logic [1:0] r_row;
    logic [1:0] r_out_row;
    logic [3:0] r_tmo;
    logic       r_mb_done;
    logic       r_err;
    logic       r_busy;
    logic       r_chroma;
    logic       r_cr;

    logic [1:0] w_state_nxt;
    logic [4:0] w_blk_nxt;
    logic [1:0] w_row_nxt;
    logic [1:0] w_out_row_nxt;
    logic [3:0] w_tmo_nxt;
    logic       w_mb_done_nxt;
    logic       w_err_nxt;
    logic       w_row_acc;

    assign w_row_acc = (r_state == ST_LOAD) && XXIN_VALID;

    always_comb begin
        w_state_nxt   = r_state;
        w_blk_nxt     = r_blk_idx;
        w_row_nxt     = r_row;
        w_out_row_nxt = r_out_row;
        w_tmo_nxt     = r_tmo;
        w_mb_done_nxt = 1'b0;
        w_err_nxt     = r_err;

        // A transform row arriving while nothing is draining is a protocol error
        if (YOUT_VALID && (r_state != ST_DRAIN)) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (MB_START) begin
                    w_state_nxt = ST_WAIT_DS;
                    w_blk_nxt   = '0;
                end
            end
            ST_WAIT_DS: begin
                if (QUANT_READY) begin
                    w_state_nxt = ST_LOAD;
                    w_row_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (XXIN_VALID) begin
                    w_row_nxt = r_row + 2'd1;
                    if (r_row == 2'd3) begin
                        w_state_nxt   = ST_DRAIN;
                        w_out_row_nxt = '0;
                        w_tmo_nxt     = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (YOUT_VALID) begin
                    w_tmo_nxt     = '0;
                    w_out_row_nxt = r_out_row + 2'd1;
                    if (r_out_row == 2'd3) begin
                        if (r_blk_idx == LAST_BLK) begin
                            w_state_nxt   = ST_IDLE;
                            w_mb_done_nxt = 1'b1;
                        end else begin
                            w_blk_nxt   = r_blk_idx + 5'd1;
                            w_state_nxt = ST_WAIT_DS;
                        end
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status flags are registered from next-state values so they line up with BLK_IDX
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_blk_idx <= '0;
            r_row     <= '0;
            r_out_row <= '0;
            r_tmo     <= '0;
            r_mb_done <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_chroma  <= 1'b0;
            r_cr      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_blk_idx <= w_blk_nxt;
            r_row     <= w_row_nxt;
            r_out_row <= w_out_row_nxt;
            r_tmo     <= w_tmo_nxt;
            r_mb_done <= w_mb_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_chroma  <= (w_blk_nxt >= CB_FIRST);
            r_cr      <= (w_blk_nxt >= CR_FIRST);
        end
    end

    assign XXIN_READY  = (r_state == ST_LOAD);
    assign CT_ROW_LOAD = w_row_acc;
    assign CT_ENABLE   = w_row_acc && (r_row == 2'd0);
    assign OUT_ROW     = (r_state == ST_DRAIN) ? r_out_row : 2'd0;
    assign BLK_IDX     = r_blk_idx;
    assign BLK_CHROMA  = r_chroma;
    assign BLK_CR      = r_cr;
    assign MB_DONE     = r_mb_done;
    assign BUSY        = r_busy;
    assign ERR         = r_err;

endmodule

// File: doc/h264coretransform_mb_sequencer.md
H264CORETRANSFORM_MB_SEQUENCER -- requirements
Module: h264coretransform_mb_sequencer

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 24, meaning 4x4 blocks per macroblock (16 luma, 4 Cb, 4 Cr).
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max cycles waiting for a transform output row.
REQ-003 CLK  input  1  clock, rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 MB_START  input  1  pulse to begin one macroblock.
REQ-006 XXIN_VALID  input  1  upstream residual row valid.
REQ-007 XXIN_READY  output  1  sequencer accepts a residual row this cycle.
REQ-008 QUANT_READY  input  1  downstream quantiser can take a new block.
REQ-009 CT_ENABLE  output  1  start pulse to the core transform, coincident with row 0.
REQ-010 CT_ROW_LOAD  output  1  row strobe to the transform; high on every accepted row.
REQ-011 YOUT_VALID  input  1  transform output row valid.
REQ-012 BLK_IDX  output  5  index of the block in flight, 0..NUM_BLOCKS-1.
REQ-013 BLK_CHROMA  output  1  block index >= 16.
REQ-014 BLK_CR  output  1  block index >= 20.
REQ-015 OUT_ROW  output  2  output row number, aligned with YOUT_VALID.
REQ-016 MB_DONE  output  1  one-cycle pulse after the last row of the last block.
REQ-017 BUSY  output  1  high in any state other than IDLE.
REQ-018 ERR  output  1  sticky protocol or timeout error flag.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_DS, LOAD, DRAIN.
REQ-020 IDLE -> WAIT_DS on MB_START; BLK_IDX cleared to 0.
REQ-021 WAIT_DS -> LOAD in the cycle after QUANT_READY is sampled high.
REQ-022 LOAD: XXIN_READY=1; a row is accepted when XXIN_VALID=1; row counter counts 0..3; CT_ROW_LOAD=1 on each accepted row; CT_ENABLE=1 on the row-0 accept only.
REQ-023 LOAD holds with no counter change while XXIN_VALID=0.
REQ-024 LOAD -> DRAIN on the row-3 accept.
REQ-025 DRAIN counts YOUT_VALID rows 0..3 and drives OUT_ROW with the current count combinationally.
REQ-026 On the 4th YOUT_VALID in DRAIN with BLK_IDX<NUM_BLOCKS-1: BLK_IDX increments and the FSM goes to WAIT_DS.
REQ-027 On the 4th YOUT_VALID in DRAIN with BLK_IDX=NUM_BLOCKS-1: MB_DONE pulses in the next cycle and the FSM goes to IDLE.
REQ-028 Only one block SHALL be in flight; no row is accepted in DRAIN.
REQ-029 Timeout counter (4 bits) clears on each YOUT_VALID and on DRAIN entry; at TIMEOUT it sets ERR and forces IDLE.
REQ-030 MB_START outside IDLE SHALL be ignored.
REQ-031 YOUT_VALID outside DRAIN SHALL set ERR and be otherwise ignored.
REQ-032 XXIN_READY SHALL be 0 outside LOAD.
REQ-033 MB_START in the cycle MB_DONE is high SHALL be accepted, because the FSM is already in IDLE.
REQ-034 All outputs SHALL be registered except XXIN_READY, CT_ROW_LOAD, CT_ENABLE and OUT_ROW, which are decoded from state and counters.

Reset
REQ-035 RESET SHALL force IDLE and clear BLK_IDX, the row, output and timeout counters, MB_DONE and ERR; it is effective mid-block.
REQ-036 In reset, every output SHALL be 0.
REQ-037 ERR SHALL clear only on RESET.

Structure
REQ-038 State enum, NUM_BLOCKS, the chroma boundaries (16, 20) and the TIMEOUT default SHALL live in shared package h264coretransform_pkg.
REQ-039 The design SHALL be a single module with no sub-modules; all counters are inline.

Verification
REQ-040 MB_START, QUANT_READY=1, continuous XXIN_VALID, YOUT_VALID 4 rows 2 cycles after each load -> 24 CT_ENABLE pulses, BLK_IDX 0..23, BLK_CHROMA rises at 16, BLK_CR rises at 20, a single MB_DONE.
REQ-041 QUANT_READY=0 for 10 cycles in WAIT_DS -> no XXIN_READY, BLK_IDX held, LOAD begins the cycle after QUANT_READY is sampled high.
REQ-042 XXIN_VALID gaps of 3 cycles between rows -> CT_ROW_LOAD exactly 4 times per block, CT_ENABLE only with row 0.
REQ-043 No YOUT_VALID for 15 cycles in DRAIN -> ERR=1, BUSY=0; MB_START then restarts at BLK_IDX=0 with ERR still 1.
REQ-044 RESET asserted in LOAD at block 7 row 2 -> all outputs 0 in the next cycle; a new MB_START begins at block 0.
REQ-045 Stray YOUT_VALID in IDLE -> ERR=1; MB_START in the MB_DONE cycle -> BUSY=1 in the next cycle.
